// File: rtl/joybus_tx_if.sv
// Joybus transmitter request/status bundle: frame request from the
// sequencer, open-drain pull-low enable and busy/done status back.
interface joybus_tx_if;
  logic        tx_start;
  logic [63:0] tx_data;
  logic [6:0]  tx_nbits;
  logic        tx_stop_dev;
  logic        jb_drive_low;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_start, tx_data, tx_nbits, tx_stop_dev,
    input  jb_drive_low, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, tx_nbits, tx_stop_dev,
    output jb_drive_low, tx_busy, tx_done
  );
endinterface

// File: rtl/joybus_tx.sv
// Joybus frame serialiser: MSB-first pulse-width bits plus a console- or
// device-length stop bit, emitted as a registered open-drain pull-low enable.
module joybus_tx #(
  parameter int CLKS_PER_US = 100
) (
  input  logic        clk,
  input  logic        rst,
  joybus_tx_if.slave  bus
);

  localparam int T    = 4 * CLKS_PER_US;
  localparam int PH_W = (T > 1) ? $clog2(T) : 1;

  // Phase lengths are loaded minus one; the counter expires at zero.
  localparam logic [PH_W-1:0] LOW1_M1  = PH_W'(CLKS_PER_US - 1);
  localparam logic [PH_W-1:0] LOW0_M1  = PH_W'(3 * CLKS_PER_US - 1);
  localparam logic [PH_W-1:0] HIGH1_M1 = PH_W'(3 * CLKS_PER_US - 1);
  localparam logic [PH_W-1:0] HIGH0_M1 = PH_W'(CLKS_PER_US - 1);
  localparam logic [PH_W-1:0] STOPC_M1 = PH_W'(CLKS_PER_US - 1);
  localparam logic [PH_W-1:0] STOPD_M1 = PH_W'(2 * CLKS_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   cnt;
  logic [6:0]        nbits_q;
  logic              stop_dev_q;
  logic [63:0]       shreg;
  logic              accept;
  logic              shift_en;

  function automatic logic [6:0] sat_nbits(input logic [6:0] n);
    return (n > 7'd64) ? 7'd64 : n;
  endfunction

  function automatic logic [PH_W-1:0] low_m1(input logic b);
    return b ? LOW1_M1 : LOW0_M1;
  endfunction

  function automatic logic [PH_W-1:0] high_m1(input logic b);
    return b ? HIGH1_M1 : HIGH0_M1;
  endfunction

  function automatic logic [PH_W-1:0] stop_m1(input logic dev);
    return dev ? STOPD_M1 : STOPC_M1;
  endfunction

  assign accept   = (state == IDLE) && bus.tx_start && !bus.tx_busy;
  assign shift_en = (state == BIT_HIGH) && (cnt == '0);

  // Frame shadow is pure data: no reset, only loaded on accept and shifted per bit.
  always_ff @(posedge clk) begin
    if (accept)
      shreg <= bus.tx_data;
    else if (shift_en)
      shreg <= {shreg[62:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      nbits_q          <= '0;
      stop_dev_q       <= 1'b0;
      bus.jb_drive_low <= 1'b0;
      bus.tx_busy      <= 1'b0;
      bus.tx_done      <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.tx_busy      <= 1'b1;
            bus.jb_drive_low <= 1'b1;
            stop_dev_q       <= bus.tx_stop_dev;
            nbits_q          <= sat_nbits(bus.tx_nbits);
            if (sat_nbits(bus.tx_nbits) == 7'd0) begin
              state <= STOP_LOW;
              cnt   <= stop_m1(bus.tx_stop_dev);
            end else begin
              state <= BIT_LOW;
              cnt   <= low_m1(bus.tx_data[63]);
            end
          end
        end
        BIT_LOW: begin
          if (cnt == '0) begin
            state            <= BIT_HIGH;
            bus.jb_drive_low <= 1'b0;
            cnt              <= high_m1(shreg[63]);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BIT_HIGH: begin
          if (cnt == '0) begin
            nbits_q          <= nbits_q - 7'd1;
            bus.jb_drive_low <= 1'b1;
            if (nbits_q == 7'd1) begin
              state <= STOP_LOW;
              cnt   <= stop_m1(stop_dev_q);
            end else begin
              // Next bit is shreg[62]: the shift lands on this same edge.
              state <= BIT_LOW;
              cnt   <= low_m1(shreg[62]);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP_LOW: begin
          if (cnt == '0) begin
            state            <= DONE;
            bus.jb_drive_low <= 1'b0;
            bus.tx_busy      <= 1'b0;
            bus.tx_done      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state            <= IDLE;
          bus.jb_drive_low <= 1'b0;
          bus.tx_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx: frames are captured as low/high run lengths,
// decoded back to bits and compared with hand-computed expectations.
module tb_joybus_tx;

  localparam int CPU = 100;
  localparam int T   = 4 * CPU;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  joybus_tx_if jb();

  joybus_tx #(.CLKS_PER_US(CPU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (jb.slave)
  );

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [6:0]  nbits;
    logic        stop_dev;
    int          exp_nb;
    logic [63:0] exp_dec;
    int          exp_stop;
    int          exp_len;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends one frame and records the pull-low waveform until tx_done or timeout.
  task automatic send_frame(input logic [63:0] d, input logic [6:0] nb, input logic sd,
                            input int exp_nb, input int inject_at,
                            output int flen, output int stop_len, output logic [63:0] dec,
                            output bit widths_ok, output bit busy_ok, output bit done_ok);
    int   runs[$];
    int   cur_len;
    logic cur_lvl;
    int   cyc;
    bit   got_done;
    @(negedge clk);
    jb.tx_data = d; jb.tx_nbits = nb; jb.tx_stop_dev = sd; jb.tx_start = 1'b1;
    @(negedge clk);
    jb.tx_start = 1'b0; jb.tx_data = ~d; jb.tx_nbits = 7'd5; jb.tx_stop_dev = ~sd;
    cyc = 0; cur_lvl = jb.jb_drive_low; cur_len = 0;
    widths_ok = (cur_lvl == 1'b1); busy_ok = 1'b1; got_done = 1'b0;
    dec = '0; stop_len = -1;
    while (cyc < 30000) begin
      if (jb.tx_done) begin
        got_done = 1'b1;
        break;
      end
      if (!jb.tx_busy) busy_ok = 1'b0;
      if (jb.jb_drive_low != cur_lvl) begin
        runs.push_back(cur_len);
        cur_lvl = jb.jb_drive_low;
        cur_len = 0;
      end
      cur_len++;
      if (inject_at >= 0 && cyc == inject_at) begin
        jb.tx_start = 1'b1; jb.tx_data = 64'hFFFF_FFFF_FFFF_FFFF; jb.tx_nbits = 7'd64;
      end else begin
        jb.tx_start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    runs.push_back(cur_len);
    flen = got_done ? cyc : -1;
    done_ok = got_done && !jb.tx_busy && !jb.jb_drive_low;
    @(negedge clk);
    if (jb.tx_done) done_ok = 1'b0;
    if (runs.size() != 2 * exp_nb + 1) begin
      widths_ok = 1'b0;
    end else begin
      for (int i = 0; i < exp_nb; i++) begin
        if (runs[2*i] == CPU) dec[63-i] = 1'b1;
        else if (runs[2*i] != 3 * CPU) widths_ok = 1'b0;
        if (runs[2*i] + runs[2*i+1] != T) widths_ok = 1'b0;
      end
      stop_len = runs[2*exp_nb];
    end
  endtask

  task automatic run_vec(input vec_t v, input int inject_at);
    int flen, stop_len;
    logic [63:0] dec;
    bit w_ok, b_ok, d_ok;
    send_frame(v.data, v.nbits, v.stop_dev, v.exp_nb, inject_at,
               flen, stop_len, dec, w_ok, b_ok, d_ok);
    chk({v.name, " frame_len"}, 64'(flen), 64'(v.exp_len));
    chk({v.name, " stop_low"}, 64'(stop_len), 64'(v.exp_stop));
    chk({v.name, " decoded"}, dec, v.exp_dec);
    chk({v.name, " bit_widths_ok"}, 64'(w_ok), 64'd1);
    chk({v.name, " busy_throughout"}, 64'(b_ok), 64'd1);
    chk({v.name, " done_single"}, 64'(d_ok), 64'd1);
  endtask

  initial begin
    int extra;
    vecs[0] = '{"byte", 64'h8000_0000_0000_0000, 7'd8, 1'b0, 8,
                64'h8000_0000_0000_0000, 100, 3300};
    vecs[1] = '{"poll", 64'h4003_0000_0000_0000, 7'd24, 1'b0, 24,
                64'h4003_0000_0000_0000, 100, 9700};
    vecs[2] = '{"full", 64'h0080_8080_8080_0000, 7'd64, 1'b1, 64,
                64'h0080_8080_8080_0000, 200, 25800};
    vecs[3] = '{"zero_bits", 64'hFFFF_FFFF_FFFF_FFFF, 7'd0, 1'b0, 0,
                64'h0, 100, 100};
    vecs[4] = '{"clamp_100", 64'hA5A5_0F0F_1234_5678, 7'd100, 1'b0, 64,
                64'hA5A5_0F0F_1234_5678, 100, 25700};

    jb.tx_start = 1'b0; jb.tx_data = '0; jb.tx_nbits = '0; jb.tx_stop_dev = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset drive_low", 64'(jb.jb_drive_low), 64'd0);
    chk("reset busy", 64'(jb.tx_busy), 64'd0);
    chk("reset done", 64'(jb.tx_done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], -1);

    // Start pulse mid-frame must be dropped, with no queued second frame.
    run_vec(vecs[0], 1000);
    extra = 0;
    repeat (500) begin
      @(negedge clk);
      if (jb.jb_drive_low || jb.tx_done || jb.tx_busy) extra++;
    end
    chk("busy_protect no_second_frame", 64'(extra), 64'd0);

    // Reset during the second bit's low phase.
    @(negedge clk);
    jb.tx_data = 64'h8000_0000_0000_0000; jb.tx_nbits = 7'd8; jb.tx_stop_dev = 1'b0;
    jb.tx_start = 1'b1;
    @(negedge clk);
    jb.tx_start = 1'b0;
    repeat (450) @(negedge clk);
    chk("midframe in_bit_low", 64'(jb.jb_drive_low), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst drive_low", 64'(jb.jb_drive_low), 64'd0);
    chk("async_rst busy", 64'(jb.tx_busy), 64'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (jb.tx_done) extra++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (jb.tx_done || jb.jb_drive_low) extra++;
    end
    chk("async_rst no_done", 64'(extra), 64'd0);
    run_vec(vecs[0], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
